// File: rtl/spi_fsm.sv
// spi_fsm - transaction controller for the SPI memory peripheral.
//
// Counts conditioned serial-clock edges, consumes the shift register's R/W
// bit and sequences one command byte (7-bit address + R/W) followed by one
// data byte read from or written to memory.
//
// Ports:
//   clk        system clock, all state updates on posedge
//   reset      asynchronous active-high reset
//   cs_n       conditioned chip select, active low
//   sclk_rise  one-clk strobe, serial clock rising edge
//   sclk_fall  one-clk strobe, serial clock falling edge
//   rw_bit     shift register bit 0 (1 = read, 0 = write)
//   sr_we      shift register parallel load
//   addr_we    address latch write enable
//   dm_we      data memory write enable
//   miso_bufe  MISO output buffer enable
//   state_o    low 3 bits of the state register (DONE reads as 0)
module spi_fsm #(
  parameter int width = 8,
  parameter int cnt_w = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       sclk_rise,
  input  logic       sclk_fall,
  input  logic       rw_bit,
  output logic       sr_we,
  output logic       addr_we,
  output logic       dm_we,
  output logic       miso_bufe,
  output logic [2:0] state_o
);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    GET_ADDR    = 4'd1,
    ADDR_LATCH  = 4'd2,
    READ_WAIT   = 4'd3,
    READ_LOAD   = 4'd4,
    READ_SHIFT  = 4'd5,
    WRITE_GET   = 4'd6,
    WRITE_STORE = 4'd7,
    DONE        = 4'd8
  } state_t;

  localparam logic [cnt_w-1:0] LP_WIDTH = cnt_w'(width);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [cnt_w-1:0]   r_cnt;
  logic [cnt_w-1:0]   w_cnt_nxt;
  logic [cnt_w-1:0]   w_cnt_inc;
  logic               w_last;

  // Saturating increment; w_last marks the edge that completes a field, so
  // the transition happens on the same posedge as the final count.
  always_comb begin
    w_cnt_inc = (r_cnt < LP_WIDTH) ? r_cnt + cnt_w'(1) : r_cnt;
    w_last    = (r_cnt == LP_WIDTH - cnt_w'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    // Deselect aborts any transaction, overriding every strobe.
    if (cs_n && r_state != IDLE) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_nxt = '0;
          if (!cs_n) w_state_nxt = GET_ADDR;
        end
        GET_ADDR: begin
          if (sclk_rise) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_last) w_state_nxt = ADDR_LATCH;
          end
        end
        ADDR_LATCH: begin
          w_cnt_nxt   = '0;
          w_state_nxt = rw_bit ? READ_WAIT : WRITE_GET;
        end
        READ_WAIT: w_state_nxt = READ_LOAD;
        READ_LOAD: begin
          w_cnt_nxt   = '0;
          w_state_nxt = READ_SHIFT;
        end
        READ_SHIFT: begin
          if (sclk_fall) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_last) w_state_nxt = DONE;
          end
        end
        WRITE_GET: begin
          if (sclk_rise) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_last) w_state_nxt = WRITE_STORE;
          end
        end
        WRITE_STORE: w_state_nxt = DONE;
        DONE:        w_state_nxt = DONE;
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    sr_we     = 1'b0;
    addr_we   = 1'b0;
    dm_we     = 1'b0;
    miso_bufe = 1'b0;
    case (r_state)
      ADDR_LATCH:  addr_we   = 1'b1;
      READ_LOAD:   sr_we     = 1'b1;
      READ_SHIFT:  miso_bufe = 1'b1;
      WRITE_STORE: dm_we     = 1'b1;
      default: ;
    endcase
    state_o = r_state[2:0];
  end

endmodule

// File: tb/tb_spi_fsm.sv
// tb_spi_fsm - self-checking bench for spi_fsm.
// Every cycle the DUT outputs are compared with a timeline model that tracks
// a transaction by edge counts and the cycle at which each field completed.
module tb_spi_fsm;

  localparam int W = 8;

  logic       clk;
  logic       reset;
  logic       cs_n;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       rw_bit;
  logic       sr_we;
  logic       addr_we;
  logic       dm_we;
  logic       miso_bufe;
  logic [2:0] state_o;

  spi_fsm #(.width(W), .cnt_w(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cs_n      (cs_n),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .rw_bit    (rw_bit),
    .sr_we     (sr_we),
    .addr_we   (addr_we),
    .dm_we     (dm_we),
    .miso_bufe (miso_bufe),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_tcmd: cycle whose posedge counted the 8th address rise
  // m_tend: cycle whose posedge counted the 8th data edge
  int m_cyc = 0;
  bit m_in;
  bit m_rd;
  int m_nrise;
  int m_ndata;
  int m_tcmd;
  int m_tend;

  function automatic void m_clear();
    m_in = 0; m_rd = 0; m_nrise = 0; m_ndata = 0; m_tcmd = -1; m_tend = -1;
  endfunction

  function automatic void m_edge(input bit rst, cs, r, f, rw);
    m_cyc++;
    if (rst || cs) m_clear();
    else if (!m_in) begin
      m_clear();
      m_in = 1;
    end else if (m_tcmd < 0) begin
      if (r) begin
        m_nrise++;
        if (m_nrise == W) m_tcmd = m_cyc;
      end
    end else begin
      if (m_cyc == m_tcmd + 1) m_rd = rw;
      if (m_tend < 0) begin
        if (!m_rd && m_cyc >= m_tcmd + 2 && r) begin
          m_ndata++;
          if (m_ndata == W) m_tend = m_cyc;
        end
        if (m_rd && m_cyc >= m_tcmd + 4 && f) begin
          m_ndata++;
          if (m_ndata == W) m_tend = m_cyc;
        end
      end
    end
  endfunction

  function automatic logic [6:0] E(input bit sr, aw, dw, mb, input int st);
    return {sr, aw, dw, mb, 3'(st)};
  endfunction

  function automatic logic [6:0] m_exp();
    int age;
    if (!m_in) return E(0, 0, 0, 0, 0);
    if (m_tcmd < 0) return E(0, 0, 0, 0, 1);
    age = m_cyc - m_tcmd;
    if (age == 0) return E(0, 1, 0, 0, 2);
    if (m_rd) begin
      if (age == 1) return E(0, 0, 0, 0, 3);
      if (age == 2) return E(1, 0, 0, 0, 4);
      if (m_tend < 0) return E(0, 0, 0, 1, 5);
      return E(0, 0, 0, 0, 0);
    end
    if (m_tend < 0) return E(0, 0, 0, 0, 6);
    if (m_cyc == m_tend) return E(0, 0, 1, 0, 7);
    return E(0, 0, 0, 0, 0);
  endfunction

  // ---------------- stimulus step + activity stats ----------------
  logic [6:0] got;
  int aw_n, aw_cyc, sr_n, sr_cyc, dm_n, mb_n, mb_first, mb_last;

  function automatic void stats_clear();
    aw_n = 0; aw_cyc = -1; sr_n = 0; sr_cyc = -1; dm_n = 0;
    mb_n = 0; mb_first = -1; mb_last = -1;
  endfunction

  task automatic step(input logic rst, cs, r, f, rw);
    reset = rst; cs_n = cs; sclk_rise = r; sclk_fall = f; rw_bit = rw;
    @(posedge clk);
    m_edge(rst, cs, r, f, rw);
    #1;
    got = {sr_we, addr_we, dm_we, miso_bufe, state_o};
    chk($sformatf("model cyc%0d", m_cyc), int'(got), int'(m_exp()));
    if (addr_we) begin aw_n++; aw_cyc = m_cyc; end
    if (sr_we) begin sr_n++; sr_cyc = m_cyc; end
    if (dm_we) dm_n++;
    if (miso_bufe) begin
      mb_n++;
      if (mb_first < 0) mb_first = m_cyc;
      mb_last = m_cyc;
    end
  endtask

  // Select, then 8 address rises spaced 4 clks apart; returns the 8th-rise cycle.
  task automatic read_cmd(output int k8);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < W; i++) begin
      repeat (3) step(0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 1);
    end
    k8 = m_cyc;
  endtask

  typedef struct {
    logic       rst, cs, r, f, rw;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic rst, cs, r, f, rw, input logic [6:0] exp);
    vec_t v;
    v.rst = rst; v.cs = cs; v.r = r; v.f = f; v.rw = rw; v.exp = exp;
    tbl.push_back(v);
  endfunction

  initial begin
    int k8, kf;

    // Write transaction with simultaneous strobes and a 4-rise overrun.
    add(0, 0, 0, 0, 0, E(0, 0, 0, 0, 1));
    for (int i = 0; i < 7; i++) add(0, 0, 1, (i == 3), 0, E(0, 0, 0, 0, 1));
    add(0, 0, 1, 0, 0, E(0, 1, 0, 0, 2));
    add(0, 0, 1, 0, 0, E(0, 0, 0, 0, 6));
    add(0, 0, 1, 1, 0, E(0, 0, 0, 0, 6));
    for (int i = 0; i < 6; i++) add(0, 0, 1, 0, 0, E(0, 0, 0, 0, 6));
    add(0, 0, 0, 1, 0, E(0, 0, 0, 0, 6));
    add(0, 0, 1, 0, 0, E(0, 0, 1, 0, 7));
    for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 0, E(0, 0, 0, 0, 0));
    add(0, 1, 0, 0, 0, E(0, 0, 0, 0, 0));

    reset = 1'b1; cs_n = 1'b1; sclk_rise = 1'b0; sclk_fall = 1'b0; rw_bit = 1'b0;
    m_clear();
    stats_clear();

    // Reset state
    step(1, 1, 0, 0, 0);
    chk("reset_outputs", int'(got), 0);
    step(1, 0, 1, 1, 1);
    chk("reset_hold", int'(got), 0);
    step(0, 1, 0, 0, 0);

    // Table-driven write
    stats_clear();
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].cs, tbl[i].r, tbl[i].f, tbl[i].rw);
      chk($sformatf("vec%0d", i), int'(got), int'(tbl[i].exp));
    end
    chk("wr_addr_we_count", aw_n, 1);
    chk("wr_dm_we_count", dm_n, 1);
    chk("wr_sr_we_count", sr_n, 0);
    chk("wr_miso_count", mb_n, 0);

    // Read of address 0x2A, falls 4 clks apart; 3rd fall coincides with a rise
    stats_clear();
    read_cmd(k8);
    kf = 0;
    for (int i = 0; i < W; i++) begin
      repeat (3) step(0, 0, 0, 0, 1);
      step(0, 0, (i == 2), 1, 1);
      kf = m_cyc;
    end
    repeat (4) step(0, 0, 1, 1, 1);
    chk("rd_addr_we_count", aw_n, 1);
    chk("rd_addr_we_time", aw_cyc, k8);
    chk("rd_sr_we_count", sr_n, 1);
    chk("rd_sr_we_time", sr_cyc, k8 + 2);
    chk("rd_miso_first", mb_first, k8 + 3);
    chk("rd_miso_last", mb_last, kf - 1);
    chk("rd_miso_len", mb_n, kf - k8 - 3);
    chk("rd_dm_we_count", dm_n, 0);
    step(0, 1, 0, 0, 0);

    // Abort after 5 address rises, then a fresh command
    stats_clear();
    step(0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("abort_state", int'(state_o), 0);
    step(0, 0, 0, 0, 0);
    repeat (7) step(0, 0, 1, 0, 0);
    chk("abort_no_early_addr_we", aw_n, 0);
    step(0, 0, 1, 0, 0);
    chk("abort_addr_we_after_8", int'(addr_we), 1);
    step(0, 1, 0, 0, 0);

    // Asynchronous reset in the middle of READ_SHIFT
    read_cmd(k8);
    repeat (4) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    chk("pre_reset_miso", int'(miso_bufe), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_miso", int'(miso_bufe), 0);
    chk("async_reset_state", int'(state_o), 0);
    m_clear();
    step(1, 1, 0, 1, 1);
    repeat (3) begin
      step(0, 1, 1, 1, 1);
      chk("post_reset_idle", int'(got), 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(399) == 0), ($urandom_range(149) == 0),
           ($urandom_range(2) == 0), ($urandom_range(2) == 0), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_fsm.md
Name: spi_fsm

Overview:
- Transaction controller for the SPI memory peripheral.
- Sits beside the shift register. It counts conditioned serial-clock edges and consumes the shift register's R/W bit.
- It drives the shift register's parallel load, the address latch write-enable, the data memory write-enable and the MISO tri-state enable.
- Each transaction is one 8-bit command byte (7-bit address, then R/W as the last bit shifted in), followed by one 8-bit data byte read from or written to memory.

Parameters:
- width, 8, bits per command/data field; equals the shift register width.
- cnt_w, 4, bit-counter width; must satisfy 2^cnt_w > width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- cs_n  input  1  conditioned chip select, active low.
- sclk_rise  input  1  one-clk-wide strobe: serial clock rising edge (same strobe that shifts the shift register).
- sclk_fall  input  1  one-clk-wide strobe: serial clock falling edge.
- rw_bit  input  1  shift register parallel output bit 0; 1 = read, 0 = write.
- sr_we  output  1  shift register parallel load.
- addr_we  output  1  address latch write enable.
- dm_we  output  1  data memory write enable.
- miso_bufe  output  1  MISO output buffer enable.
- state_o  output  3  current state encoding, for debug.

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - state = IDLE, counter = 0.
  - sr_we = addr_we = dm_we = miso_bufe = 0.
  - No pulse may leak on the reset cycle.
- Outputs are Moore: decoded from the state register only; no input-to-output combinational path.
- State encoding: IDLE=0, GET_ADDR=1, ADDR_LATCH=2, READ_WAIT=3, READ_LOAD=4, READ_SHIFT=5, WRITE_GET=6, WRITE_STORE=7 … DONE is the ninth state, so use a 4-bit state register; state_o reports its low 3 bits, with DONE reported as 0 (same as IDLE). Bench must treat state_o==0 as IDLE or DONE.
- cs_n=1 priority: on any posedge with cs_n=1 and state != IDLE, go to IDLE and clear the counter. This overrides every edge strobe and every other transition.
- IDLE:
  - cs_n=0 → GET_ADDR, counter=0.
- GET_ADDR:
  - Each sclk_rise increments the counter; sclk_fall is ignored.
  - Counter reaches width (from the increment on that edge) → ADDR_LATCH on the next posedge.
  - The shift register has captured bit width-1 on that same posedge, so rw_bit is valid in ADDR_LATCH.
- ADDR_LATCH (1 cycle):
  - addr_we=1.
  - rw_bit=1 → READ_WAIT; rw_bit=0 → WRITE_GET.
  - Counter cleared.
- READ_WAIT (1 cycle): all outputs 0; covers the memory read latency → READ_LOAD.
- READ_LOAD (1 cycle): sr_we=1 → READ_SHIFT, counter=0.
- READ_SHIFT:
  - miso_bufe=1.
  - Each sclk_fall increments the counter; sclk_rise is ignored.
  - Counter reaches width → DONE.
- WRITE_GET:
  - Each sclk_rise increments the counter.
  - Counter reaches width → WRITE_STORE.
- WRITE_STORE (1 cycle): dm_we=1 → DONE.
- DONE:
  - All outputs 0.
  - Holds until cs_n=1 → IDLE. Extra serial clocks are ignored.
- Both strobes high in one cycle: each state looks only at its own edge, as defined above.
- Counter:
  - Saturates at width; never wraps.
  - Only increments in GET_ADDR, WRITE_GET and READ_SHIFT.
- Pulse widths: addr_we, sr_we and dm_we are each exactly one clk wide per transaction; never asserted twice.

Test Plan:
- Reset mid-READ_SHIFT → within the same cycle, miso_bufe=0 and state_o=0. After release with cs_n=1, stays IDLE with all outputs 0.
- Read of address 0x2A:
  - Stimulus: cs_n=0; 8 sclk_rise strobes, 4 clks apart; rw_bit=1 in ADDR_LATCH.
  - addr_we pulses exactly 1 clk, one clk after the 8th rise.
  - sr_we pulses exactly 1 clk, 2 clks after addr_we.
  - miso_bufe high from the next clk until 8 sclk_fall strobes have occurred.
  - Then DONE; dm_we never asserted.
- Write:
  - Stimulus: command with rw_bit=0, then 8 more sclk_rise strobes.
  - addr_we 1 clk; dm_we exactly 1 clk, one clk after the 8th data rise.
  - sr_we and miso_bufe never asserted.
- Abort: cs_n→1 after 5 address rises → next posedge state_o=0. A fresh transaction then starts counting from 0 (addr_we appears only after 8 new rises).
- Simultaneous strobes: sclk_rise=sclk_fall=1 for one clk during GET_ADDR → counter increments exactly once. During READ_SHIFT → counter increments exactly once.
- Overrun: 12 sclk_rise strobes in a write → dm_we pulses once; the 4 extra rises in DONE cause no output activity.
